sketch_counter_update: RTL

SKETCH_COUNTER_UPDATE -- requirements
Module: sketch_counter_update

---
 rtl/sketch_pkg.sv | 28 ++
 rtl/sketch_counter_update_if.sv | 24 ++
 rtl/sketch_pair_fifo.sv | 51 +++++
 rtl/sketch_counter_update.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sketch_pkg.sv
// Shared definitions for the sketch counter update block:
// FSM encoding, default parameters and a saturating helper.
package sketch_pkg;

    localparam int unsigned ADDR_WIDTH_D = 19;
    localparam int unsigned ROW_BITS_D   = 2;
    localparam int unsigned CNT_WIDTH_D  = 32;
    localparam int unsigned FIFO_DEPTH_D = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

    // 16-bit add of a small increment that sticks at all-ones.
    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [1:0]  inc
    );
        logic [16:0] s;
        s = {1'b0, a} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/sketch_counter_update_if.sv
// SRAM request/response bus between the sketch updater
// (master) and the memory controller (slave).
interface sketch_counter_update_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int CNT_WIDTH  = 32
);
    logic                  sram_rd_req;
    logic                  sram_wr_req;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [CNT_WIDTH-1:0]  sram_wr_data;
    logic                  sram_ready;
    logic [CNT_WIDTH-1:0]  sram_rd_data;
    logic                  sram_rd_valid;

    modport master (
        output sram_rd_req, sram_wr_req, sram_addr, sram_wr_data,
        input  sram_ready, sram_rd_data, sram_rd_valid
    );

    modport slave (
        input  sram_rd_req, sram_wr_req, sram_addr, sram_wr_data,
        output sram_ready, sram_rd_data, sram_rd_valid
    );
endinterface

// File: rtl/sketch_pair_fifo.sv
// Small synchronous FIFO used to pair hash and byte strobes;
// pushes into a full FIFO are discarded and flagged on o_drop.
module sketch_pair_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [AW:0]      o_count,
    output logic             o_drop
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_wr    = i_push && !w_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_drop  = i_push && w_full;
    assign o_data  = r_mem[r_rp];
    assign o_count = r_cnt;

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= i_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end
endmodule

// File: rtl/sketch_counter_update.sv
// Count-min sketch updater: pairs hash and length strobes,
// read-modify-writes one SRAM counter, and can zero the sketch.
module sketch_counter_update
    import sketch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int ROW_BITS   = ROW_BITS_D,
    parameter int CNT_WIDTH  = CNT_WIDTH_D,
    parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
    input  logic        memclk,
    input  logic        reset,
    input  logic [31:0] hash_data,
    input  logic        hash_valid,
    input  logic [15:0] sram_id,
    input  logic [15:0] packet_byte,
    input  logic        packet_byte_valid,
    input  logic        clear_req,
    output logic        clear_done,
    sketch_counter_update_if.master sram,
    output logic        busy,
    output logic [15:0] drop_count
);
    localparam int HW  = ROW_BITS + 32;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int LW  = ADDR_WIDTH - ROW_BITS;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_byte;
    logic [CNT_WIDTH-1:0]  r_sum;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_clr_pend;
    logic                  r_clear_done;
    logic [15:0]           r_drop;

    logic [HW-1:0]         w_h_data;
    logic [15:0]           w_b_data;
    logic                  w_h_empty;
    logic                  w_b_empty;
    logic [FAW:0]          w_h_cnt;
    logic [FAW:0]          w_b_cnt;
    logic                  w_h_drop;
    logic                  w_b_drop;
    logic                  w_pop;
    logic                  w_clr_go;
    logic                  w_clr_last;
    logic [CNT_WIDTH:0]    w_sum_ext;
    logic [CNT_WIDTH-1:0]  w_sum;
    logic [ADDR_WIDTH-1:0] w_pair_addr;
    logic                  w_unused;

    sketch_pair_fifo #(.WIDTH(HW), .DEPTH(FIFO_DEPTH)) u_hash_fifo (
        .clk     (memclk),
        .rst     (reset),
        .i_push  (hash_valid),
        .i_data  ({sram_id[ROW_BITS-1:0], hash_data}),
        .i_pop   (w_pop),
        .o_data  (w_h_data),
        .o_empty (w_h_empty),
        .o_count (w_h_cnt),
        .o_drop  (w_h_drop)
    );

    sketch_pair_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_byte_fifo (
        .clk     (memclk),
        .rst     (reset),
        .i_push  (packet_byte_valid),
        .i_data  (packet_byte),
        .i_pop   (w_pop),
        .o_data  (w_b_data),
        .o_empty (w_b_empty),
        .o_count (w_b_cnt),
        .o_drop  (w_b_drop)
    );

    // Upper id and hash bits do not take part in addressing.
    assign w_unused = ^{sram_id, w_h_data};

    assign w_pair_addr = {w_h_data[HW-1 -: ROW_BITS], w_h_data[LW-1:0]};
    assign w_clr_last  = (r_clr_addr == '1);
    assign w_sum_ext   = {1'b0, sram.sram_rd_data}
                       + (CNT_WIDTH+1)'(r_byte);
    assign w_sum       = w_sum_ext[CNT_WIDTH] ? '1
                       : w_sum_ext[CNT_WIDTH-1:0];

    // State register.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state; a pending clear wins over a new update.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_clr_go    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (clear_req || r_clr_pend) begin
                    w_state_nxt = S_CLEAR;
                    w_clr_go    = 1'b1;
                end else if (!w_h_empty && !w_b_empty) begin
                    w_state_nxt = S_RD_REQ;
                    w_pop       = 1'b1;
                end
            end
            S_RD_REQ:
                if (sram.sram_ready) w_state_nxt = S_RD_WAIT;
            S_RD_WAIT:
                if (sram.sram_rd_valid) w_state_nxt = S_WR_REQ;
            S_WR_REQ:
                if (sram.sram_ready) w_state_nxt = S_IDLE;
            S_CLEAR:
                if (sram.sram_ready && w_clr_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request outputs decode straight from state so reset idles them.
    assign sram.sram_rd_req  = (r_state == S_RD_REQ);
    assign sram.sram_wr_req  = (r_state == S_WR_REQ)
                            || (r_state == S_CLEAR);
    assign sram.sram_addr    = (r_state == S_CLEAR) ? r_clr_addr
                             : ((r_state == S_RD_REQ)
                             || (r_state == S_RD_WAIT)
                             || (r_state == S_WR_REQ)) ? r_addr : '0;
    assign sram.sram_wr_data = (r_state == S_WR_REQ) ? r_sum : '0;

    assign busy       = (r_state != S_IDLE)
                     || (w_h_cnt != '0) || (w_b_cnt != '0);
    assign clear_done = r_clear_done;
    assign drop_count = r_drop;

    // Update datapath, clear sweep, pending clear and drop counter.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_byte       <= '0;
            r_sum        <= '0;
            r_clr_addr   <= '0;
            r_clr_pend   <= 1'b0;
            r_clear_done <= 1'b0;
            r_drop       <= '0;
        end else begin
            if (w_pop) begin
                r_addr <= w_pair_addr;
                r_byte <= w_b_data;
            end
            if (r_state == S_RD_WAIT && sram.sram_rd_valid)
                r_sum <= w_sum;
            if (w_clr_go)
                r_clr_addr <= '0;
            else if (r_state == S_CLEAR && sram.sram_ready)
                r_clr_addr <= r_clr_addr + 1'b1;
            r_clr_pend   <= (r_clr_pend || clear_req) && !w_clr_go;
            r_clear_done <= (r_state == S_CLEAR) && sram.sram_ready
                         && w_clr_last;
            r_drop       <= sat_add16(r_drop,
                            {w_h_drop & w_b_drop, w_h_drop ^ w_b_drop});
        end
    end
endmodule
